// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Round-robin arbiter and init sequencer in front of the memory controller's
//   logic-side port. NUM_REQ requesters share one write channel and one read
//   channel. One write and one read can be granted per cycle. After reset, or on
//   initStart, the whole memory is first swept with INIT_VALUE.
//
// Ports
//   clockCore, resetCore      : clock, synchronous active-low reset
//   initStart / initBusy      : re-run request / sweep in progress
//   reqVld/reqWr/reqAddr/reqWrData : per-requester request (slice i = requester i)
//   reqGnt                    : per-requester grant, same cycle as the request
//   rspVld / rspData          : read response, one cycle after a read grant
//   ctrlMemWr*/ctrlMemRd*     : write/read channels to the memory controller
//   ctrlMemRdData             : controller read data, one cycle after ctrlMemRd
module mem_port_arb #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    NUM_REQ    = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                            clockCore,
    input  logic                            resetCore,
    input  logic                            initStart,
    output logic                            initBusy,
    input  logic [NUM_REQ-1:0]              reqVld,
    input  logic [NUM_REQ-1:0]              reqWr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   reqAddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   reqWrData,
    output logic [NUM_REQ-1:0]              reqGnt,
    output logic [NUM_REQ-1:0]              rspVld,
    output logic [DATA_WIDTH-1:0]           rspData,
    output logic                            ctrlMemWr,
    output logic [ADDR_WIDTH-1:0]           ctrlMemWrAddr,
    output logic [DATA_WIDTH-1:0]           ctrlMemWrData,
    output logic                            ctrlMemRd,
    output logic [ADDR_WIDTH-1:0]           ctrlMemRdAddr,
    input  logic [DATA_WIDTH-1:0]           ctrlMemRdData
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   initCnt_q, initCnt_d;
    logic [PW-1:0]           wrPtr_q, wrPtr_d;
    logic [PW-1:0]           rdPtr_q, rdPtr_d;
    logic [NUM_REQ-1:0]      rspVld_q, rspVld_d;

    logic [NUM_REQ-1:0]      wrCand, rdCand;
    logic [PW-1:0]           wrIdx, rdIdx;
    logic [NUM_REQ-1:0]      wrGnt, rdGnt;
    logic                    memWr, memRd;
    logic [ADDR_WIDTH-1:0]   memWrAddr, memRdAddr;
    logic [DATA_WIDTH-1:0]   memWrData;

    // First candidate at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                              input logic [PW-1:0] ptr);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Write and read candidates are disjoint by access type, so a requester
    // can never hold both grants in the same cycle.
    assign wrCand = reqVld & reqWr;
    assign rdCand = reqVld & ~reqWr;
    assign wrIdx  = rr_pick(wrCand, wrPtr_q);
    assign rdIdx  = rr_pick(rdCand, rdPtr_q);

    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        wrGnt     = '0;
        rdGnt     = '0;
        memWr     = 1'b0;
        memWrAddr = '0;
        memWrData = '0;
        memRd     = 1'b0;
        memRdAddr = '0;
        case (state_q)
            ST_INIT: begin
                memWr     = 1'b1;
                memWrAddr = initCnt_q;
                memWrData = INIT_VALUE;
                // Counter wraps back to 0 on the last address.
                initCnt_d = initCnt_q + 1'b1;
                if (&initCnt_q) state_d = ST_RUN;
            end
            default: begin
                if (|wrCand) begin
                    wrGnt[wrIdx] = 1'b1;
                    memWr        = 1'b1;
                    memWrAddr    = reqAddr[wrIdx*ADDR_WIDTH +: ADDR_WIDTH];
                    memWrData    = reqWrData[wrIdx*DATA_WIDTH +: DATA_WIDTH];
                    wrPtr_d      = ptr_inc(wrIdx);
                end
                if (|rdCand) begin
                    rdGnt[rdIdx] = 1'b1;
                    memRd        = 1'b1;
                    memRdAddr    = reqAddr[rdIdx*ADDR_WIDTH +: ADDR_WIDTH];
                    rdPtr_d      = ptr_inc(rdIdx);
                end
                // Grants in this cycle still go out; the sweep starts next edge.
                if (initStart) begin
                    state_d   = ST_INIT;
                    initCnt_d = '0;
                end
            end
        endcase
        rspVld_d = rdGnt;
    end

    always_ff @(posedge clockCore) begin
        if (!resetCore) begin
            state_q   <= ST_INIT;
            initCnt_q <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            rspVld_q  <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            rspVld_q  <= rspVld_d;
        end
    end

    // While reset is held every output is forced quiet, initBusy excepted.
    assign initBusy      = ~resetCore | (state_q == ST_INIT);
    assign reqGnt        = resetCore ? (wrGnt | rdGnt) : '0;
    assign rspVld        = resetCore ? rspVld_q : '0;
    assign rspData       = resetCore ? ctrlMemRdData : '0;
    assign ctrlMemWr     = resetCore & memWr;
    assign ctrlMemWrAddr = resetCore ? memWrAddr : '0;
    assign ctrlMemWrData = resetCore ? memWrData : '0;
    assign ctrlMemRd     = resetCore & memRd;
    assign ctrlMemRdAddr = resetCore ? memRdAddr : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam logic [DW-1:0] IV = 16'h5A3C;

    logic              clockCore = 1'b0;
    logic              resetCore;
    logic              initStart;
    logic              initBusy;
    logic [NR-1:0]     reqVld, reqWr, reqGnt, rspVld;
    logic [NR*AW-1:0]  reqAddr;
    logic [NR*DW-1:0]  reqWrData;
    logic [DW-1:0]     rspData;
    logic              ctrlMemWr, ctrlMemRd;
    logic [AW-1:0]     ctrlMemWrAddr, ctrlMemRdAddr;
    logic [DW-1:0]     ctrlMemWrData, ctrlMemRdData;

    mem_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_VALUE(IV)) dut (
        .clockCore(clockCore), .resetCore(resetCore), .initStart(initStart),
        .initBusy(initBusy), .reqVld(reqVld), .reqWr(reqWr), .reqAddr(reqAddr),
        .reqWrData(reqWrData), .reqGnt(reqGnt), .rspVld(rspVld), .rspData(rspData),
        .ctrlMemWr(ctrlMemWr), .ctrlMemWrAddr(ctrlMemWrAddr), .ctrlMemWrData(ctrlMemWrData),
        .ctrlMemRd(ctrlMemRd), .ctrlMemRdAddr(ctrlMemRdAddr), .ctrlMemRdData(ctrlMemRdData)
    );

    always #5 clockCore = ~clockCore;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clockCore) cyc <= cyc + 1;

    // Memory controller model: 1-cycle read latency, write-to-read forwarding.
    logic [DW-1:0] mem [256];
    initial for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;
    always @(posedge clockCore) begin
        if (ctrlMemWr) mem[ctrlMemWrAddr] <= ctrlMemWrData;
        if (ctrlMemRd)
            ctrlMemRdData <= (ctrlMemWr && ctrlMemWrAddr == ctrlMemRdAddr) ? ctrlMemWrData
                                                                            : mem[ctrlMemRdAddr];
    end

    // Scoreboard of expected read responses.
    typedef struct {
        int            due;
        logic [NR-1:0] vec;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sb[$];

    task automatic push_rsp(input int idx, input logic [DW-1:0] d);
        rsp_t e;
        e.due = cyc + 1;
        e.vec = '0;
        e.vec[idx] = 1'b1;
        e.data = d;
        sb.push_back(e);
    endtask

    rsp_t          mon_e;
    logic [NR-1:0] mon_vec;
    logic [DW-1:0] mon_data;
    always @(negedge clockCore) begin
        #3;
        mon_vec  = '0;
        mon_data = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e    = sb.pop_front();
            mon_vec  = mon_e.vec;
            mon_data = mon_e.data;
        end
        total++;
        if (rspVld !== mon_vec) begin
            bad++;
            $display("FAIL rspVld cyc=%0d got=%b exp=%b", cyc, rspVld, mon_vec);
        end
        if (mon_vec != '0) begin
            total++;
            if (rspData !== mon_data) begin
                bad++;
                $display("FAIL rspData cyc=%0d got=%h exp=%h", cyc, rspData, mon_data);
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqVld[i] = v;
        reqWr[i]  = w;
        reqAddr[i*AW +: AW]   = a;
        reqWrData[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs;
        reqVld = '0; reqWr = '0; reqAddr = '0; reqWrData = '0;
    endtask

    // Observes one full sweep starting in the current window; ends in window 256.
    task automatic check_sweep(input string tag);
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) @(negedge clockCore);
            #2;
            if (i < 256) begin
                total++;
                if (ctrlMemWr !== 1'b1 || ctrlMemWrAddr !== AW'(i) || ctrlMemWrData !== IV) begin
                    bad++;
                    $display("FAIL %s_wr i=%0d got=%b/%h/%h exp=1/%h/%h", tag, i,
                             ctrlMemWr, ctrlMemWrAddr, ctrlMemWrData, AW'(i), IV);
                end
                total++;
                if (initBusy !== 1'b1 || reqGnt !== '0 || ctrlMemRd !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_busy i=%0d got busy=%b gnt=%b rd=%b exp 1/0000/0", tag, i,
                             initBusy, reqGnt, ctrlMemRd);
                end
            end
        end
    endtask

    task automatic test_reset;
        resetCore = 1'b0; initStart = 1'b0;
        clear_reqs();
        reqVld = '1; reqWr = 4'b0101;
        repeat (3) begin
            @(negedge clockCore); #2;
            total++;
            if (initBusy !== 1'b1 || reqGnt !== '0 || ctrlMemWr !== 1'b0 || ctrlMemRd !== 1'b0
                || ctrlMemWrAddr !== '0 || ctrlMemWrData !== '0 || rspData !== '0) begin
                bad++;
                $display("FAIL reset_outputs got busy=%b gnt=%b wr=%b rd=%b wa=%h wd=%h rs=%h exp 1,0...",
                         initBusy, reqGnt, ctrlMemWr, ctrlMemRd, ctrlMemWrAddr, ctrlMemWrData, rspData);
            end
        end
    endtask

    // Release reset; req2 asks for a read at cycle 10 and waits out the sweep.
    task automatic test_init_with_read;
        @(negedge clockCore);
        resetCore = 1'b1;
        clear_reqs();
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) @(negedge clockCore);
            if (i == 10) set_req(2, 1'b1, 1'b0, 8'h07, '0);
            #2;
            if (i < 256) begin
                total++;
                if (ctrlMemWr !== 1'b1 || ctrlMemWrAddr !== AW'(i) || ctrlMemWrData !== IV) begin
                    bad++;
                    $display("FAIL init_wr i=%0d got=%b/%h/%h exp=1/%h/%h", i,
                             ctrlMemWr, ctrlMemWrAddr, ctrlMemWrData, AW'(i), IV);
                end
                total++;
                if (initBusy !== 1'b1 || reqGnt !== '0 || ctrlMemRd !== 1'b0) begin
                    bad++;
                    $display("FAIL init_nogrant i=%0d got busy=%b gnt=%b exp 1/0000", i, initBusy, reqGnt);
                end
            end else begin
                total++;
                if (initBusy !== 1'b0 || reqGnt !== 4'b0100 || ctrlMemRd !== 1'b1
                    || ctrlMemRdAddr !== 8'h07) begin
                    bad++;
                    $display("FAIL init_first_run got busy=%b gnt=%b rd=%b ra=%h exp 0/0100/1/07",
                             initBusy, reqGnt, ctrlMemRd, ctrlMemRdAddr);
                end
                push_rsp(2, IV);
            end
        end
        @(negedge clockCore);
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 8'h80, '0);
        #2;
        total++;
        if (reqGnt !== 4'b0001 || ctrlMemRdAddr !== 8'h80) begin
            bad++;
            $display("FAIL read_0x80 got gnt=%b ra=%h exp 0001/80", reqGnt, ctrlMemRdAddr);
        end
        push_rsp(0, IV);
        @(negedge clockCore);
        clear_reqs();
    endtask

    task automatic test_write_rr;
        int            order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        logic [NR-1:0] g;
        @(negedge clockCore);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(8'h30 + i), DW'(16'h3000 + i));
        for (int s = 0; s < 10; s++) begin
            if (s > 0) @(negedge clockCore);
            if (s == 6) reqVld[1] = 1'b0;
            #2;
            g = '0;
            g[order[s]] = 1'b1;
            total++;
            if (reqGnt !== g || ctrlMemWr !== 1'b1 || ctrlMemWrAddr !== AW'(8'h30 + order[s])
                || ctrlMemWrData !== DW'(16'h3000 + order[s]) || ctrlMemRd !== 1'b0) begin
                bad++;
                $display("FAIL write_rr s=%0d got gnt=%b wa=%h wd=%h exp gnt=%b", s,
                         reqGnt, ctrlMemWrAddr, ctrlMemWrData, g);
            end
        end
        @(negedge clockCore);
        clear_reqs();
    endtask

    task automatic test_concurrent;
        @(negedge clockCore);
        set_req(0, 1'b1, 1'b1, 8'h05, 16'hA5A5);
        set_req(1, 1'b1, 1'b0, 8'h05, '0);
        #2;
        total++;
        if (reqGnt !== 4'b0011 || ctrlMemWr !== 1'b1 || ctrlMemWrAddr !== 8'h05
            || ctrlMemWrData !== 16'hA5A5 || ctrlMemRd !== 1'b1 || ctrlMemRdAddr !== 8'h05) begin
            bad++;
            $display("FAIL concurrent got gnt=%b wr=%b wa=%h wd=%h rd=%b ra=%h exp 0011/1/05/a5a5/1/05",
                     reqGnt, ctrlMemWr, ctrlMemWrAddr, ctrlMemWrData, ctrlMemRd, ctrlMemRdAddr);
        end
        push_rsp(1, 16'hA5A5);
        @(negedge clockCore);
        clear_reqs();
    endtask

    task automatic test_back_to_back;
        int            word[4] = '{1, 2, 3, 0};
        int            rord[4] = '{2, 3, 0, 1};
        logic [NR-1:0] g;
        @(negedge clockCore);
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(8'h20 + i), DW'(16'h1000 + i));
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                @(negedge clockCore);
                reqVld[word[s-1]] = 1'b0;
            end
            #2;
            g = '0;
            g[word[s]] = 1'b1;
            total++;
            if (reqGnt !== g || ctrlMemWrAddr !== AW'(8'h20 + word[s])
                || ctrlMemWrData !== DW'(16'h1000 + word[s])) begin
                bad++;
                $display("FAIL b2b_write s=%0d got gnt=%b wa=%h wd=%h exp gnt=%b", s,
                         reqGnt, ctrlMemWrAddr, ctrlMemWrData, g);
            end
        end
        @(negedge clockCore);
        clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(8'h20 + i), '0);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                @(negedge clockCore);
                reqVld[rord[s-1]] = 1'b0;
            end
            #2;
            g = '0;
            g[rord[s]] = 1'b1;
            total++;
            if (reqGnt !== g || ctrlMemRd !== 1'b1 || ctrlMemRdAddr !== AW'(8'h20 + rord[s])
                || ctrlMemWr !== 1'b0) begin
                bad++;
                $display("FAIL b2b_read s=%0d got gnt=%b ra=%h exp gnt=%b", s, reqGnt, ctrlMemRdAddr, g);
            end
            push_rsp(rord[s], DW'(16'h1000 + rord[s]));
        end
        @(negedge clockCore);
        clear_reqs();
    endtask

    task automatic test_init_start;
        @(negedge clockCore);
        set_req(3, 1'b1, 1'b0, 8'h23, '0);
        initStart = 1'b1;
        #2;
        total++;
        if (reqGnt !== 4'b1000 || initBusy !== 1'b0 || ctrlMemRdAddr !== 8'h23) begin
            bad++;
            $display("FAIL initstart_grant got gnt=%b busy=%b ra=%h exp 1000/0/23",
                     reqGnt, initBusy, ctrlMemRdAddr);
        end
        push_rsp(3, 16'h1003);
        @(negedge clockCore);
        initStart = 1'b0;
        clear_reqs();
        set_req(0, 1'b1, 1'b0, 8'h20, '0);
        check_sweep("restart");
        total++;
        if (initBusy !== 1'b0 || reqGnt !== 4'b0001) begin
            bad++;
            $display("FAIL restart_end got busy=%b gnt=%b exp 0/0001", initBusy, reqGnt);
        end
        push_rsp(0, IV);
        @(negedge clockCore);
        clear_reqs();
    endtask

    task automatic test_reset_mid;
        // Reset lands right after a read grant: its response must be dropped.
        @(negedge clockCore);
        set_req(2, 1'b1, 1'b0, 8'h44, '0);
        #2;
        total++;
        if (reqGnt !== 4'b0100) begin
            bad++;
            $display("FAIL midread_grant got=%b exp=0100", reqGnt);
        end
        #2;
        resetCore = 1'b0;
        clear_reqs();
        @(negedge clockCore); #2;
        total++;
        if (initBusy !== 1'b1 || rspVld !== '0) begin
            bad++;
            $display("FAIL midread_reset got busy=%b rspVld=%b exp 1/0000", initBusy, rspVld);
        end
        @(negedge clockCore);
        resetCore = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) @(negedge clockCore);
            #2;
            total++;
            if (ctrlMemWr !== 1'b1 || ctrlMemWrAddr !== AW'(i)) begin
                bad++;
                $display("FAIL partial_sweep i=%0d got=%b/%h exp=1/%h", i, ctrlMemWr, ctrlMemWrAddr, AW'(i));
            end
        end
        #2;
        resetCore = 1'b0;
        @(negedge clockCore); #2;
        total++;
        if (initBusy !== 1'b1 || ctrlMemWr !== 1'b0 || ctrlMemWrAddr !== '0) begin
            bad++;
            $display("FAIL sweep_reset got busy=%b wr=%b wa=%h exp 1/0/00", initBusy, ctrlMemWr, ctrlMemWrAddr);
        end
        @(negedge clockCore);
        resetCore = 1'b1;
        check_sweep("resweep");
        total++;
        if (initBusy !== 1'b0) begin
            bad++;
            $display("FAIL resweep_end got busy=%b exp 0", initBusy);
        end
    endtask

    initial begin
        test_reset();
        test_init_with_read();
        test_write_rr();
        test_concurrent();
        test_back_to_back();
        test_init_start();
        test_reset_mid();
        repeat (2) @(negedge clockCore);
        #4;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Round-robin arbiter and initialisation sequencer in front of the dual-port memory controller's logic-side port (ctrlMemWr*/ctrlMemRd*). It shares one write channel and one read channel among NUM_REQ DMA-side requesters and returns read data to the granted requester. After reset, or on command, it first sweeps the whole memory with INIT_VALUE. CPU access stays on the memory controller's own lower-priority port and is outside this block's scope.

## Interface
- ADDR_WIDTH, 8: memory address width; the memory depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16: memory data width.
- NUM_REQ, 4: number of requesters, 2..8.
- INIT_VALUE, 0: word written to every address during init.
- clockCore  in  1: core clock, the only clock.
- resetCore  in  1: reset, synchronous and active-low.
- initStart  in  1: single-cycle pulse that re-runs the memory init sweep.
- initBusy  out  1: high while the init sweep is running.
- reqVld  in  NUM_REQ: per-requester request. The requester holds it, with its fields stable, until it sees reqGnt.
- reqWr  in  NUM_REQ: per-requester access type; 1 = write, 0 = read.
- reqAddr  in  NUM_REQ*ADDR_WIDTH: per-requester address, with requester i in slice i.
- reqWrData  in  NUM_REQ*DATA_WIDTH: per-requester write data.
- reqGnt  out  NUM_REQ: per-requester grant, combinational in the same cycle as the request.
- rspVld  out  NUM_REQ: read-data valid for requester i.
- rspData  out  DATA_WIDTH: read data, shared by all requesters and qualified by rspVld.
- ctrlMemWr, ctrlMemWrAddr, ctrlMemWrData  out  1/ADDR_WIDTH/DATA_WIDTH: write channel to the memory controller.
- ctrlMemRd, ctrlMemRdAddr  out  1/ADDR_WIDTH: read channel to the memory controller.
- ctrlMemRdData  in  DATA_WIDTH: read data from the memory controller, valid 1 cycle after ctrlMemRd.

## Operation
- The state machine has two states: INIT and RUN.
- Reset sets state = INIT, initCnt = 0, wrPtr = 0, rdPtr = 0 and rspVld = 0.
- While resetCore is low, every output is 0 except initBusy, which is 1.
- INIT state:
  - Each cycle drives ctrlMemWr = 1, ctrlMemWrAddr = initCnt and ctrlMemWrData = INIT_VALUE, then increments initCnt.
  - The transition to RUN happens on the cycle that writes address 2^ADDR_WIDTH-1. initCnt wraps to 0.
  - No grants are issued and ctrlMemRd = 0. initStart is ignored.
- RUN state, initStart = 1: the state returns to INIT with initCnt = 0 on the next edge. Grants are still issued in the initStart cycle.
- RUN state, write arbitration:
  - Candidates are the requesters with reqVld & reqWr.
  - The winner is the first candidate found scanning upward from wrPtr, modulo NUM_REQ.
  - The winner drives the write channel, and wrPtr becomes winner+1 mod NUM_REQ.
  - With no candidate, wrPtr holds and ctrlMemWr = 0.
- RUN state, read arbitration:
  - Candidates are the requesters with reqVld & ~reqWr, using rdPtr in the same way.
  - The winner drives ctrlMemRd and ctrlMemRdAddr.
- One write and one read can be granted in the same cycle, to different requesters. A requester can never receive two grants in one cycle.
- reqGnt = write grant | read grant.
- Read response: rspVld <= the read-grant vector (registered), and rspData = ctrlMemRdData (passthrough).
- A read and a write to the same address in the same cycle are legal. The memory controller forwards the write data, so the read returns the new value.
- When ctrlMemWr = 0 or ctrlMemRd = 0, the matching address and data outputs are 0.

## Timing
- Grant latency is 0 cycles. The memory write commits at the edge that ends the grant cycle.
- Read latency is 1 cycle: rspVld[i] and valid rspData arrive exactly 1 cycle after reqGnt[i] for a read.
- Throughput is 1 write plus 1 read per cycle.
- Fairness: with all NUM_REQ continuously requesting the same type, each requester is granted once every NUM_REQ cycles.
- The init sweep takes exactly 2^ADDR_WIDTH cycles. initBusy falls in the first RUN cycle, and grants are possible in that same cycle.
- A read granted in the cycle of initStart still produces rspVld in the first INIT cycle.
- Reset asserted mid-init or mid-read:
  - Takes effect at the next edge.
  - The sweep restarts from address 0.
  - Any pending rspVld is dropped.

## Test plan
- Reset release, ADDR_WIDTH = 8:
  - ctrlMemWr is high for 256 consecutive cycles with addresses 0..255 and data INIT_VALUE.
  - initBusy drops on cycle 256, and a read of address 0x80 then returns INIT_VALUE.
- Write round-robin with all 4 requesters writing continuously: grants go 0,1,2,3,0,1. After requester 1 drops out, grants go 2,3,0,2.
- Concurrent access: req0 writes address 5 with 0xA5A5 while req1 reads address 5 in the same cycle. Both are granted; next cycle rspVld = 4'b0010 and rspData = 0xA5A5.
- Read during init: req2 asserts a read of address 7 at cycle 10 after reset. reqGnt[2] stays 0 until cycle 256, then it is granted and rspVld[2] rises at cycle 257 with INIT_VALUE.
- initStart in RUN together with a read grant to req3:
  - rspVld[3] rises the next cycle with correct data.
  - initBusy = 1 from that cycle for 256 cycles, with no grants during it.
- Reset asserted at sweep address 100: the sweep restarts at address 0 after release, and the full 256-cycle sweep is observed.
